mase_param_stream_source: RTL and testbench



---
 rtl/mase_param_src_pkg.sv | 30 +++
 rtl/mase_param_stream_source_rom_pipe.sv | 114 +++++++++++
 rtl/mase_param_stream_source.sv | 237 +++++++++++++++++++++++
 tb/tb_mase_param_stream_source.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mase_param_src_pkg.sv
// -----------------------------------------------------------------------------
// mase_param_src_pkg
//
// Shared types and sizing helpers for the parameter stream source.
//
//   state_t     : source FSM encoding (IDLE, STREAM, DRAIN). IDLE encodes as 0
//                 so a cleared state register reads back as idle.
//   fifo_depth  : output FIFO capacity for a given ROM read latency. Two extra
//                 slots beyond the read latency let reads be issued every
//                 cycle while the head beat is popped, so a ready-high
//                 consumer sees no bubbles.
//   addr_width  : counter/address width for a given range, never below 1 bit.
// -----------------------------------------------------------------------------
package mase_param_src_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    function automatic int fifo_depth(input int rom_latency);
        return rom_latency + 2;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mase_param_stream_source_rom_pipe.sv
// -----------------------------------------------------------------------------
// mase_param_rom_pipe
//
// Parameter memory plus a LATENCY-stage registered read path. A valid bit and
// a last bit ride alongside the data so the consumer of the pipe needs no
// knowledge of the latency.
//
// Word contents: element j of word a holds the flattened element index
// (a*NPAR + j), truncated to DATA_WIDTH.
//
// Optional write port (macro MASE_PARAM_SRC_WRITE_EN):
//   defined   - memory is a simple dual-port RAM, loaded with the generated
//               contents on rst. A write lands at the clock edge; a read of
//               the same address in the same cycle returns the old word.
//   undefined - memory is a constant ROM built from the generated contents.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_en               issue a read this cycle
//   rd_addr             word address of the read
//   rd_last             tag carried with the read (last beat of a pass)
//   wr_en/wr_addr/wr_data   write port (macro defined only)
//   out_valid           read result available this cycle
//   out_last            tag of the read result
//   out_data            read word
// -----------------------------------------------------------------------------
module mase_param_rom_pipe
    import mase_param_src_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NPAR       = 1,
    parameter int DEPTH      = 32,
    parameter int LATENCY    = 2,
    parameter int AW         = addr_width(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_en,
    input  logic [AW-1:0]              rd_addr,
    input  logic                       rd_last,
`ifdef MASE_PARAM_SRC_WRITE_EN
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DATA_WIDTH*NPAR-1:0] wr_data,
`endif
    output logic                       out_valid,
    output logic                       out_last,
    output logic [DATA_WIDTH*NPAR-1:0] out_data
);

    localparam int WORD_W = DATA_WIDTH * NPAR;

    function automatic logic [WORD_W-1:0] gen_word(input int unsigned a);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int j = 0; j < NPAR; j++) begin
            w[DATA_WIDTH*j +: DATA_WIDTH] = DATA_WIDTH'(a * NPAR + j);
        end
        return w;
    endfunction

    logic [WORD_W-1:0]  data_q [LATENCY];
    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] last_q;
    logic [WORD_W-1:0]  read_word;

`ifdef MASE_PARAM_SRC_WRITE_EN
    logic [WORD_W-1:0] mem [DEPTH];

    // Reset reloads the generated contents so the RAM starts from the same
    // image the read-only build would hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= gen_word(i);
            end
        end else if (wr_en && (32'(wr_addr) < 32'(DEPTH))) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Sampled into data_q[0] with a non-blocking read, so a same-cycle write
    // to the same address is not yet visible (read-first).
    assign read_word = mem[rd_addr];
`else
    assign read_word = gen_word(32'(rd_addr));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= rd_en;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Data and tag stages carry no reset: they are qualified by valid_q.
    always_ff @(posedge clk) begin
        data_q[0] <= read_word;
        last_q[0] <= rd_last;
        for (int i = 1; i < LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
            last_q[i] <= last_q[i-1];
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_last  = last_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/mase_param_stream_source.sv
// -----------------------------------------------------------------------------
// mase_param_stream_source
//
// Streams a parameter tensor out of on-chip memory as tiled beats. Each beat
// carries PAR_DIM_0*PAR_DIM_1 elements; a pass covers DEPTH beats. Reads are
// issued against a credit (in-flight reads + FIFO occupancy) so the FIFO can
// absorb every outstanding read and never overflows. One-shot mode runs
// REPEAT passes per start; continuous mode streams forever from reset.
//
// Handshake (data_out): a beat transfers on a cycle where data_out_valid and
// data_out_ready are both high. Once valid is raised it stays high, with
// data_out and data_out_last held stable, until that transfer happens; only
// rst can drop it earlier.
//
// Optional feature macro: MASE_PARAM_SRC_WRITE_EN adds wr_en/wr_addr/wr_data
// and turns the memory into a writable read-first RAM.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            begin a one-shot run (sampled only in IDLE)
//   busy             high in STREAM or DRAIN
//   done             one-cycle pulse when a one-shot run completes
//   data_out         beat; element j at [DATA_WIDTH*j +: DATA_WIDTH]
//   data_out_valid   beat valid
//   data_out_ready   consumer ready
//   data_out_last    final beat of each pass
//   state_dbg        current FSM state, for observation
//   wr_en/wr_addr/wr_data   memory write port (macro defined only)
// -----------------------------------------------------------------------------
module mase_param_stream_source
    import mase_param_src_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int TENSOR_DIM_0 = 32,
    parameter int TENSOR_DIM_1 = 1,
    parameter int PAR_DIM_0    = 1,
    parameter int PAR_DIM_1    = 1,
    parameter int ROM_LATENCY  = 2,
    parameter int REPEAT       = 1,
    parameter int CONTINUOUS   = 0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    output logic                                       busy,
    output logic                                       done,
    output logic [DATA_WIDTH*PAR_DIM_0*PAR_DIM_1-1:0]  data_out,
    output logic                                       data_out_valid,
    input  logic                                       data_out_ready,
    output logic                                       data_out_last,
    output state_t                                     state_dbg
`ifdef MASE_PARAM_SRC_WRITE_EN
    ,
    input  logic                                       wr_en,
    input  logic [addr_width((TENSOR_DIM_0/PAR_DIM_0)*(TENSOR_DIM_1/PAR_DIM_1))-1:0] wr_addr,
    input  logic [DATA_WIDTH*PAR_DIM_0*PAR_DIM_1-1:0]  wr_data
`endif
);

    localparam int NPAR   = PAR_DIM_0 * PAR_DIM_1;
    localparam int WORD_W = DATA_WIDTH * NPAR;
    localparam int DEPTH  = (TENSOR_DIM_0 / PAR_DIM_0) * (TENSOR_DIM_1 / PAR_DIM_1);
    localparam int AW     = addr_width(DEPTH);
    localparam int PW     = addr_width(REPEAT);
    localparam int FD     = fifo_depth(ROM_LATENCY);
    localparam int CW     = $clog2(FD + 1);
    localparam int PTR_W  = addr_width(FD);

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     rd_addr;
    logic [PW-1:0]     pass_cnt;
    logic [CW-1:0]     in_flight;
    logic [CW-1:0]     fifo_count;
    logic              credit_ok;
    logic              issue;
    logic              at_last_addr;
    logic              at_last_pass;
    logic              final_issue;

    logic              rom_valid;
    logic              rom_last;
    logic [WORD_W-1:0] rom_data;

    logic [WORD_W-1:0] fifo_data [FD];
    logic [FD-1:0]     fifo_last;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              fifo_valid;
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Read issue: only while every outstanding read still has a FIFO slot.
    // ------------------------------------------------------------------
    assign credit_ok    = ({1'b0, in_flight} + {1'b0, fifo_count}) < (CW + 1)'(FD);
    assign issue        = (state == STREAM) && credit_ok;
    assign at_last_addr = (rd_addr == AW'(DEPTH - 1));
    assign at_last_pass = (pass_cnt == PW'(REPEAT - 1));
    assign final_issue  = issue && at_last_addr && at_last_pass && (CONTINUOUS == 0);

    // Both counters return to 0 after the final read of a run, so the next
    // start always begins at address 0, pass 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr  <= '0;
            pass_cnt <= '0;
        end else if (issue) begin
            if (at_last_addr) begin
                rd_addr <= '0;
                if (at_last_pass || (CONTINUOUS != 0)) begin
                    pass_cnt <= '0;
                end else begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
            end else begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    // Reads issued but not yet delivered into the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            in_flight <= in_flight + CW'(issue) - CW'(push);
        end
    end

    mase_param_rom_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .NPAR       (NPAR),
        .DEPTH      (DEPTH),
        .LATENCY    (ROM_LATENCY),
        .AW         (AW)
    ) u_rom_pipe (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (issue),
        .rd_addr   (rd_addr),
        .rd_last   (at_last_addr),
`ifdef MASE_PARAM_SRC_WRITE_EN
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
`endif
        .out_valid (rom_valid),
        .out_last  (rom_last),
        .out_data  (rom_data)
    );

    // ------------------------------------------------------------------
    // Output FIFO. The head word is read straight out of the storage
    // registers, so it holds steady across stalls.
    // ------------------------------------------------------------------
    assign fifo_valid = (fifo_count != '0);
    assign push       = rom_valid;
    assign pop        = fifo_valid && data_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= rom_data;
            fifo_last[wr_ptr] <= rom_last;
        end
    end

    // Head is masked to zero while empty so outputs read 0 out of reset.
    assign data_out_valid = fifo_valid;
    assign data_out       = fifo_valid ? fifo_data[rd_ptr] : '0;
    assign data_out_last  = fifo_valid & fifo_last[rd_ptr];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if ((CONTINUOUS != 0) || start) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (final_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((fifo_count == '0) && (in_flight == '0)) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // The credit check makes overflow unreachable; trip loudly if it is.
    fifo_overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_count == CW'(FD))));

endmodule

// File: tb/tb_mase_param_stream_source.sv
// -----------------------------------------------------------------------------
// tb_mase_param_stream_source
//
// Directed bench for mase_param_stream_source. Four instances share one
// clock, each with its own reset and handshake signals:
//   a : one-shot, DEPTH=8 (8x2 tensor, 2x1 beats), REPEAT=1
//   b : as a, REPEAT=3
//   c : as a, CONTINUOUS=1
//   d : one-shot, DEPTH=1, REPEAT=3
// With MASE_PARAM_SRC_WRITE_EN defined, a and b also exercise the write port.
// Word a of the DEPTH=8 tensor holds elements {2a+1, 2a} (16 bits each).
// -----------------------------------------------------------------------------
module tb_mase_param_stream_source;
    import mase_param_src_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Hand-computed word table: element1 = 2a+1, element0 = 2a.
    logic [31:0] words [8] = '{
        32'h0001_0000, 32'h0003_0002, 32'h0005_0004, 32'h0007_0006,
        32'h0009_0008, 32'h000B_000A, 32'h000D_000C, 32'h000F_000E
    };
    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    logic a_rst, a_start, a_busy, a_done, a_valid, a_ready, a_last;
    logic b_rst, b_start, b_busy, b_done, b_valid, b_ready, b_last;
    logic c_rst, c_start, c_busy, c_done, c_valid, c_ready, c_last;
    logic d_rst, d_start, d_busy, d_done, d_valid, d_ready, d_last;
    logic [31:0] a_data, b_data, c_data, d_data;
    state_t a_state, b_state, c_state, d_state;
`ifdef MASE_PARAM_SRC_WRITE_EN
    logic        a_wr_en, b_wr_en;
    logic [2:0]  a_wr_addr, b_wr_addr;
    logic [31:0] a_wr_data, b_wr_data;
`endif

    mase_param_stream_source #(
        .DATA_WIDTH(16), .TENSOR_DIM_0(8), .TENSOR_DIM_1(2), .PAR_DIM_0(2), .PAR_DIM_1(1),
        .ROM_LATENCY(2), .REPEAT(1), .CONTINUOUS(0)
    ) u_a (
        .clk(clk), .rst(a_rst), .start(a_start), .busy(a_busy), .done(a_done),
        .data_out(a_data), .data_out_valid(a_valid), .data_out_ready(a_ready),
        .data_out_last(a_last), .state_dbg(a_state)
`ifdef MASE_PARAM_SRC_WRITE_EN
        , .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
`endif
    );

    mase_param_stream_source #(
        .DATA_WIDTH(16), .TENSOR_DIM_0(8), .TENSOR_DIM_1(2), .PAR_DIM_0(2), .PAR_DIM_1(1),
        .ROM_LATENCY(2), .REPEAT(3), .CONTINUOUS(0)
    ) u_b (
        .clk(clk), .rst(b_rst), .start(b_start), .busy(b_busy), .done(b_done),
        .data_out(b_data), .data_out_valid(b_valid), .data_out_ready(b_ready),
        .data_out_last(b_last), .state_dbg(b_state)
`ifdef MASE_PARAM_SRC_WRITE_EN
        , .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
`endif
    );

    mase_param_stream_source #(
        .DATA_WIDTH(16), .TENSOR_DIM_0(8), .TENSOR_DIM_1(2), .PAR_DIM_0(2), .PAR_DIM_1(1),
        .ROM_LATENCY(2), .REPEAT(1), .CONTINUOUS(1)
    ) u_c (
        .clk(clk), .rst(c_rst), .start(c_start), .busy(c_busy), .done(c_done),
        .data_out(c_data), .data_out_valid(c_valid), .data_out_ready(c_ready),
        .data_out_last(c_last), .state_dbg(c_state)
`ifdef MASE_PARAM_SRC_WRITE_EN
        , .wr_en(1'b0), .wr_addr(3'd0), .wr_data(32'd0)
`endif
    );

    mase_param_stream_source #(
        .DATA_WIDTH(16), .TENSOR_DIM_0(2), .TENSOR_DIM_1(1), .PAR_DIM_0(2), .PAR_DIM_1(1),
        .ROM_LATENCY(2), .REPEAT(3), .CONTINUOUS(0)
    ) u_d (
        .clk(clk), .rst(d_rst), .start(d_start), .busy(d_busy), .done(d_done),
        .data_out(d_data), .data_out_valid(d_valid), .data_out_ready(d_ready),
        .data_out_last(d_last), .state_dbg(d_state)
`ifdef MASE_PARAM_SRC_WRITE_EN
        , .wr_en(1'b0), .wr_addr(1'b0), .wr_data(32'd0)
`endif
    );

    // Scoreboard: expected {last, data} per beat, in order.
    logic [32:0] exp_q [$];
    int          beats, done_cnt, done_cyc, first_valid, last_beat_cyc;
    logic        prev_stall;
    logic [32:0] prev_word;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_mon();
        exp_q.delete();
        beats         = 0;
        done_cnt      = 0;
        done_cyc      = -1;
        first_valid   = -1;
        last_beat_cyc = -1;
        prev_stall    = 1'b0;
        prev_word     = '0;
    endtask

    // Called once per cycle, after inputs for that cycle are driven.
    task automatic mon(input string tag, input logic v, input logic r, input logic l,
                       input logic [31:0] d, input logic dn, input int k);
        logic [32:0] obs;
        obs = {l, d};
        if (prev_stall) begin
            chk({tag, "_hold_valid"}, 64'(v), 64'd1);
            chk({tag, "_hold_word"}, 64'(obs), 64'(prev_word));
        end
        if (v && first_valid < 0) first_valid = k;
        if (v && r) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL %s_extra_beat observed=%0h expected=none", tag, obs);
            end
            if (exp_q.size() != 0) chk({tag, "_beat"}, 64'(obs), 64'(exp_q.pop_front()));
            beats++;
            last_beat_cyc = k;
        end
        if (dn) begin
            done_cnt++;
            done_cyc = k;
        end
        prev_stall = v && !r;
        prev_word  = obs;
    endtask

    task automatic push_pass(input int n, input int last_every);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({((i % last_every) == last_every - 1), words[i % 8]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        a_rst = 1; b_rst = 1; c_rst = 1; d_rst = 1;
        a_start = 0; b_start = 0; c_start = 0; d_start = 0;
        a_ready = 0; b_ready = 0; c_ready = 0; d_ready = 0;
`ifdef MASE_PARAM_SRC_WRITE_EN
        a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0;
        b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0;
`endif
        reset_mon();
        repeat (3) tick();

        // ---- reset state ----
        chk("rst_a_valid", 64'(a_valid), 64'd0);
        chk("rst_a_busy",  64'(a_busy),  64'd0);
        chk("rst_a_done",  64'(a_done),  64'd0);
        chk("rst_a_last",  64'(a_last),  64'd0);
        chk("rst_a_data",  64'(a_data),  64'd0);
        chk("rst_a_state", 64'(a_state), 64'(IDLE));
        chk("rst_c_valid", 64'(c_valid), 64'd0);
        chk("rst_c_busy",  64'(c_busy),  64'd0);
        a_rst = 0; b_rst = 0; d_rst = 0;
        tick();
        chk("idle_a_busy", 64'(a_busy), 64'd0);

        // ---- one-shot, ready high ----
        reset_mon();
        push_pass(8, 8);
        a_ready = 1;
        for (int i = 0; i < 15; i++) begin
            a_start = (i == 0);
            mon("a_oneshot", a_valid, a_ready, a_last, a_data, a_done, i);
            if (i == 3)  chk("a_state_stream", 64'(a_state), 64'(STREAM));
            if (i == 10) chk("a_state_drain", 64'(a_state), 64'(DRAIN));
            if (i == 12) chk("a_busy_at_done", 64'(a_busy), 64'd1);
            if (i == 13) chk("a_busy_after_done", 64'(a_busy), 64'd0);
            tick();
        end
        a_start = 0;
        chk("a_first_valid", 64'(first_valid), 64'd4);
        chk("a_beats", 64'(beats), 64'd8);
        chk("a_last_beat_cyc", 64'(last_beat_cyc), 64'd11);
        chk("a_done_cyc", 64'(done_cyc), 64'd12);
        chk("a_done_cnt", 64'(done_cnt), 64'd1);

        // ---- backpressure 1,0,0,1,0 ----
        reset_mon();
        push_pass(8, 8);
        for (k = 0; k < 120 && done_cnt == 0; k++) begin
            a_start = (k == 0);
            a_ready = pat[k % 5];
            mon("a_bp", a_valid, a_ready, a_last, a_data, a_done, k);
            tick();
        end
        a_start = 0; a_ready = 1;
        chk("a_bp_done", 64'(done_cnt), 64'd1);
        chk("a_bp_beats", 64'(beats), 64'd8);
        chk("a_bp_left", 64'(exp_q.size()), 64'd0);
        chk("a_bp_idle", 64'(a_busy), 64'd0);

        // ---- REPEAT=3 ----
        reset_mon();
        push_pass(24, 8);
        b_ready = 1;
        for (int i = 0; i < 32; i++) begin
            b_start = (i == 0);
            mon("b_rep", b_valid, b_ready, b_last, b_data, b_done, i);
            tick();
        end
        b_start = 0;
        chk("b_first_valid", 64'(first_valid), 64'd4);
        chk("b_beats", 64'(beats), 64'd24);
        chk("b_last_beat_cyc", 64'(last_beat_cyc), 64'd27);
        chk("b_done_cyc", 64'(done_cyc), 64'd28);
        chk("b_done_cnt", 64'(done_cnt), 64'd1);

        // ---- CONTINUOUS ----
        reset_mon();
        push_pass(20, 8);
        c_ready = 1;
        c_rst = 0;
        tick();
        for (int i = 0; i < 23; i++) begin
            c_start = (i == 10);
            mon("c_cont", c_valid, c_ready, c_last, c_data, c_done, i);
            tick();
        end
        c_start = 0;
        chk("c_first_valid", 64'(first_valid), 64'd3);
        chk("c_beats", 64'(beats), 64'd20);
        chk("c_last_beat_cyc", 64'(last_beat_cyc), 64'd22);
        chk("c_done_cnt", 64'(done_cnt), 64'd0);
        chk("c_busy", 64'(c_busy), 64'd1);
        c_rst = 1;
        tick();
        chk("c_rst_valid", 64'(c_valid), 64'd0);

        // ---- reset at handshake of beat 3 ----
        reset_mon();
        push_pass(8, 8);
        a_ready = 1;
        for (int i = 0; i < 8; i++) begin
            a_start = (i == 0);
            mon("a_abort", a_valid, a_ready, a_last, a_data, a_done, i);
            if (i == 7) a_rst = 1;
            tick();
        end
        a_start = 0;
        chk("a_abort_beats", 64'(beats), 64'd4);
        chk("a_abort_valid", 64'(a_valid), 64'd0);
        chk("a_abort_busy", 64'(a_busy), 64'd0);
        a_rst = 0;
        tick();
        tick();
        reset_mon();
        push_pass(8, 8);
        for (k = 0; k < 60 && done_cnt == 0; k++) begin
            a_start = (k == 0 || k == 6);
            mon("a_restart", a_valid, a_ready, a_last, a_data, a_done, k);
            tick();
        end
        a_start = 0;
        chk("a_restart_first", 64'(first_valid), 64'd4);
        chk("a_restart_beats", 64'(beats), 64'd8);
        chk("a_restart_done", 64'(done_cnt), 64'd1);
        repeat (3) tick();
        chk("a_restart_idle", 64'(a_busy), 64'd0);
        chk("a_restart_novalid", 64'(a_valid), 64'd0);

        // ---- DEPTH=1 ----
        reset_mon();
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 32'h0001_0000});
        d_ready = 1;
        for (int i = 0; i < 12; i++) begin
            d_start = (i == 0);
            mon("d_depth1", d_valid, d_ready, d_last, d_data, d_done, i);
            tick();
        end
        d_start = 0;
        chk("d_first_valid", 64'(first_valid), 64'd4);
        chk("d_beats", 64'(beats), 64'd3);
        chk("d_done_cyc", 64'(done_cyc), 64'd7);
        chk("d_done_cnt", 64'(done_cnt), 64'd1);

`ifdef MASE_PARAM_SRC_WRITE_EN
        // ---- write in IDLE, then stream ----
        a_wr_en = 1; a_wr_addr = 3'd5; a_wr_data = 32'h0000_ABCD;
        tick();
        a_wr_en = 0;
        reset_mon();
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), (i == 5) ? 32'h0000_ABCD : words[i]});
        for (k = 0; k < 60 && done_cnt == 0; k++) begin
            a_start = (k == 0);
            mon("a_wr", a_valid, a_ready, a_last, a_data, a_done, k);
            tick();
        end
        a_start = 0;
        chk("a_wr_beats", 64'(beats), 64'd8);

        // ---- write colliding with the read of addr 5 (issued at cycle 6) ----
        reset_mon();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back({(i == 7), (i == 5 && p > 0) ? 32'h0000_1234 : words[i]});
            end
        end
        b_wr_addr = 3'd5; b_wr_data = 32'h0000_1234;
        for (k = 0; k < 80 && done_cnt == 0; k++) begin
            b_start = (k == 0);
            b_wr_en = (k == 6);
            mon("b_wr", b_valid, b_ready, b_last, b_data, b_done, k);
            tick();
        end
        b_start = 0; b_wr_en = 0;
        chk("b_wr_beats", 64'(beats), 64'd24);
        chk("b_wr_left", 64'(exp_q.size()), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
